wb_burst_reader: RTL and testbench
==================================

// Module: wb_burst_reader
// PURPOSE
//  Wishbone master: reads a block of 32-bit words from a Wishbone slave (e.g. BRAM, SDRAM ctrl)
//  with incrementing bursts (cti=3'b010/3'b111), pushes them into an internal FIFO drained by a
//  consumer (video/stream side). Initiator counterpart of the memory slaves in controleur_memoire.
// PARAMETERS
//  BURST_LEN   8   max beats per Wishbone burst (>=1)
//  FIFO_DEPTH  16  words in read FIFO, power of 2, >= BURST_LEN
// PORTS
//  wb_m.clk     input   1   system clock (carried by wshb_if)
//  wb_m.rst     input   1   synchronous active-high reset (carried by wshb_if)
//  wb_m         master  -   wshb_if.master: adr,dat_ms,dat_sm,we,sel,stb,cyc,cti,bte,ack,err,rty
//  start        input   1   1-cycle request, sampled only in IDLE
//  base_adr     input   32  byte address of first word, bits[1:0] ignored (forced 0)
//  word_count   input   16  number of words to read
//  busy         output  1   high from accepted start until done
//  done         output  1   1-cycle pulse at end of transfer
//  err_flag     output  1   sticky error, cleared on next accepted start
//  rd_en        input   1   consumer pop request
//  rd_data      output  32  FIFO head word (valid when rd_valid)
//  rd_valid     output  1   FIFO not empty
// BEHAVIOUR
//  Reset: cyc=stb=0, cti=3'b000, adr=0, busy=0, done=0, err_flag=0, FIFO emptied, FSM=IDLE.
//  Static outputs: we=0, sel=4'hF, dat_ms=0, bte=2'b00.
//  FSM IDLE -> (start) latch adr=base_adr&~3, rem=word_count, busy=1:
//    rem==0 -> DONE; else WAIT_SPACE. start while busy: ignored.
//  WAIT_SPACE: blen=min(BURST_LEN,rem); when FIFO free slots >= blen, next cycle cyc=stb=1, -> BURST.
//  BURST: cyc/stb held until every beat acked; adr,cti registered, update on ack edge.
//    cti: blen==1 -> 3'b000 (classic); else 3'b010 on beats 1..blen-1, 3'b111 on last beat.
//    Each ack: push dat_sm to FIFO, adr+=4 (32-bit wrap, no error), rem--, beat++.
//    Last ack: cyc=stb=0 on same edge; rem>0 -> WAIT_SPACE (>=1 idle cycle between bursts),
//    rem==0 -> DONE.
//  DONE: done=1 for one cycle, busy=0 after it, -> IDLE.
//  rty: treated as no ack (stb stays high, beat retried). Slave wait states: any number.
//  FIFO: first-word-fall-through; rd_data valid same cycle as rd_valid; pop on rd_en&rd_valid.
//    rd_en on empty ignored. Push+pop same cycle: both happen, count unchanged.
//    Space check guarantees push never hits full; overflow impossible by construction.
//  Reset mid-burst: cyc/stb drop on the reset edge, FIFO and counters cleared, no done pulse.
// CONFIGURATION
//  WB_READER_ERR_EN defined: err during BURST ends cycle (cyc=stb=0), no push, err_flag=1,
//    -> DONE (remaining words abandoned).
//  Not defined: err ignored (treated like no ack); err_flag tied 0.
// TESTING
//  1) base_adr=0x100, word_count=8, slave ack every cycle -> one burst, cti 010x7 then 111,
//     adr 0x100..0x11C, 8 words in FIFO in order, done 1 cycle after last ack.
//  2) word_count=20, BURST_LEN=8, rd_en=0 (FIFO_DEPTH=16) -> bursts 8,8 then stall;
//     pop 4 words -> final burst of 4; total 20 words, values match memory.
//  3) word_count=1 -> single classic cycle cti=000, one word, done; word_count=0 -> done only,
//     cyc never high.
//  4) slave inserts 3 wait states per beat, rd_en=1 permanently -> data order preserved,
//     stb held, push+pop same cycle keeps FIFO count at <=1.
//  5) assert rst during beat 3 of burst -> cyc=stb=0 next edge, rd_valid=0, busy=0, no done pulse;
//     new start works normally.
//  6) WB_READER_ERR_EN: err on beat 2 of burst at 0x200 -> 1 word pushed, err_flag=1, done pulse;
//     without macro same stimulus -> err ignored, all words read once slave acks.

Source files
------------

// File: rtl/wb_burst_reader_if.sv
// ----------------------------------------------------------------------------
// wshb_if : 32-bit Wishbone bus bundle shared by masters and slaves.
//
// Ports
//    clk     system clock
//    rst     synchronous active-high reset
// Signals
//    adr     byte address (master -> slave)
//    dat_ms  write data    (master -> slave)
//    dat_sm  read data     (slave -> master)
//    we      write enable
//    sel     byte lane selects
//    stb     strobe
//    cyc     bus cycle in progress
//    cti     cycle type identifier (000 classic, 010 incrementing, 111 end)
//    bte     burst type extension
//    ack     normal termination
//    err     error termination
//    rty     retry termination
// ----------------------------------------------------------------------------
interface wshb_if (
   input logic clk,
   input logic rst
);
   logic [31:0] adr;
   logic [31:0] dat_ms;
   logic [31:0] dat_sm;
   logic        we;
   logic [3:0]  sel;
   logic        stb;
   logic        cyc;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic        ack;
   logic        err;
   logic        rty;

   modport master (
      input  clk, rst, dat_sm, ack, err, rty,
      output adr, dat_ms, we, sel, stb, cyc, cti, bte
   );

   modport slave (
      input  clk, rst, adr, dat_ms, we, sel, stb, cyc, cti, bte,
      output dat_sm, ack, err, rty
   );
endinterface

// File: rtl/wb_burst_reader.sv
// ----------------------------------------------------------------------------
// wb_burst_reader : Wishbone master that reads a block of 32-bit words using
// incrementing bursts and queues them in a first-word-fall-through FIFO for a
// streaming consumer.
//
// Build option
//    WB_READER_ERR_EN  when defined, a slave err during a burst aborts the
//                      transfer and sets err_flag; otherwise err is treated
//                      like a missing ack and err_flag stays 0.
//
// Parameters
//    BURST_LEN   maximum beats per Wishbone burst (>= 1)
//    FIFO_DEPTH  read FIFO depth in words, power of two, >= BURST_LEN
//
// Ports
//    wb_m        Wishbone master port (carries clk and synchronous rst)
//    start       one-cycle transfer request, honoured only when idle
//    base_adr    byte address of the first word (bits [1:0] ignored)
//    word_count  number of words to read (0 = immediate done)
//    busy        high from accepted start until the done cycle ends
//    done        one-cycle pulse at end of transfer
//    err_flag    sticky bus error, cleared by the next accepted start
//    rd_en       consumer pop request
//    rd_data     FIFO head word, valid whenever rd_valid is high
//    rd_valid    FIFO not empty
// ----------------------------------------------------------------------------
module wb_burst_reader #(
   parameter int BURST_LEN  = 8,
   parameter int FIFO_DEPTH = 16
) (
   wshb_if.master        wb_m,
   input  logic          start,
   input  logic [31:0]   base_adr,
   input  logic [15:0]   word_count,
   output logic          busy,
   output logic          done,
   output logic          err_flag,
   input  logic          rd_en,
   output logic [31:0]   rd_data,
   output logic          rd_valid
);

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int BLEN_W = $clog2(BURST_LEN + 1);

   localparam logic [1:0] ST_IDLE       = 2'd0;
   localparam logic [1:0] ST_WAIT_SPACE = 2'd1;
   localparam logic [1:0] ST_BURST      = 2'd2;
   localparam logic [1:0] ST_DONE       = 2'd3;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_END     = 3'b111;

   // ------------------------------------------------------------------
   // Transfer control state
   // ------------------------------------------------------------------
   logic [1:0]        state_reg;
   logic [31:0]       adr_reg;
   logic [15:0]       rem_reg;
   logic [BLEN_W-1:0] blen_reg;
   logic [BLEN_W-1:0] beat_reg;
   logic              cyc_reg;
   logic [2:0]        cti_reg;
   logic              err_reg;

   // ------------------------------------------------------------------
   // FIFO state
   // ------------------------------------------------------------------
   logic [31:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [PTR_W-1:0]  rd_ptr_next;
   logic [CNT_W-1:0]  count_reg;
   logic [31:0]       rd_data_reg;

   logic              push;
   logic              pop;
   logic              beat_ack;
   logic              bus_err;
   logic [BLEN_W-1:0] blen_calc;
   logic              space_ok;
   logic              last_beat;
   logic [2:0]        cti_after_ack;
   logic [3:0]        sel_vec;

   // ------------------------------------------------------------------
   // Static bus outputs: read-only master, all byte lanes, linear bursts
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_sel
         assign sel_vec[gi] = 1'b1;
      end
   endgenerate

   assign wb_m.we     = 1'b0;
   assign wb_m.sel    = sel_vec;
   assign wb_m.dat_ms = 32'h0000_0000;
   assign wb_m.bte    = 2'b00;
   assign wb_m.adr    = adr_reg;
   assign wb_m.cyc    = cyc_reg;
   // stb and cyc always move together: the master never idles inside a burst.
   assign wb_m.stb    = cyc_reg;
   assign wb_m.cti    = cti_reg;

   // ------------------------------------------------------------------
   // Beat termination decode. rty (and err in the default build) simply
   // leave the beat pending so it is presented again.
   // ------------------------------------------------------------------
`ifdef WB_READER_ERR_EN
   assign bus_err  = cyc_reg & wb_m.err;
`else
   assign bus_err  = 1'b0;
`endif
   assign beat_ack = cyc_reg & wb_m.ack & ~wb_m.rty & ~wb_m.err;

   // Length of the next burst and whether the FIFO can absorb all of it.
   // Reserving the whole burst up front is what makes overflow impossible.
   assign blen_calc = (rem_reg < 16'(BURST_LEN)) ? BLEN_W'(rem_reg) : BLEN_W'(BURST_LEN);
   assign space_ok  = (32'(count_reg) + 32'(blen_calc)) <= 32'(FIFO_DEPTH);

   // beat_reg counts beats already acked in the current burst.
   assign last_beat     = (beat_reg + BLEN_W'(1)) == blen_reg;
   assign cti_after_ack = ((beat_reg + BLEN_W'(2)) == blen_reg) ? CTI_END : CTI_INCR;

   // ------------------------------------------------------------------
   // Transfer FSM
   // ------------------------------------------------------------------
   always_ff @(posedge wb_m.clk) begin
      if (wb_m.rst) begin
         state_reg <= ST_IDLE;
         adr_reg   <= 32'h0000_0000;
         rem_reg   <= 16'h0000;
         blen_reg  <= '0;
         beat_reg  <= '0;
         cyc_reg   <= 1'b0;
         cti_reg   <= CTI_CLASSIC;
         err_reg   <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  adr_reg   <= {base_adr[31:2], 2'b00};
                  rem_reg   <= word_count;
                  err_reg   <= 1'b0;
                  state_reg <= (word_count == 16'h0000) ? ST_DONE : ST_WAIT_SPACE;
               end
            end

            ST_WAIT_SPACE: begin
               if (space_ok) begin
                  cyc_reg   <= 1'b1;
                  blen_reg  <= blen_calc;
                  beat_reg  <= '0;
                  cti_reg   <= (blen_calc == BLEN_W'(1)) ? CTI_CLASSIC : CTI_INCR;
                  state_reg <= ST_BURST;
               end
            end

            ST_BURST: begin
               if (bus_err) begin
                  // Remaining words are abandoned; the current beat is not stored.
                  cyc_reg   <= 1'b0;
                  cti_reg   <= CTI_CLASSIC;
                  err_reg   <= 1'b1;
                  state_reg <= ST_DONE;
               end else if (beat_ack) begin
                  adr_reg  <= adr_reg + 32'd4;
                  rem_reg  <= rem_reg - 16'd1;
                  beat_reg <= beat_reg + BLEN_W'(1);
                  if (last_beat) begin
                     cyc_reg   <= 1'b0;
                     cti_reg   <= CTI_CLASSIC;
                     state_reg <= (rem_reg == 16'd1) ? ST_DONE : ST_WAIT_SPACE;
                  end else begin
                     cti_reg <= cti_after_ack;
                  end
               end
            end

            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy     = (state_reg != ST_IDLE);
   assign done     = (state_reg == ST_DONE);
   assign err_flag = err_reg;

   // ------------------------------------------------------------------
   // Read FIFO (first-word-fall-through)
   // ------------------------------------------------------------------
   assign push     = (state_reg == ST_BURST) & beat_ack;
   assign rd_valid = (count_reg != '0);
   assign pop      = rd_en & rd_valid;

   always_comb begin
      rd_ptr_next = rd_ptr_reg;
      if (pop) begin
         rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
   end

   always_ff @(posedge wb_m.clk) begin
      if (wb_m.rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         rd_ptr_reg <= rd_ptr_next;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Storage with a registered read of the next head address. When the
   // word being written is the one that becomes the head (FIFO empty after
   // this cycle's pop), the incoming data bypasses the array so the head is
   // presented on the very next cycle.
   always_ff @(posedge wb_m.clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= wb_m.dat_sm;
      end
      if (push && (wr_ptr_reg == rd_ptr_next)) begin
         rd_data_reg <= wb_m.dat_sm;
      end else begin
         rd_data_reg <= fifo_mem[rd_ptr_next];
      end
   end

   assign rd_data = rd_data_reg;

endmodule

// File: tb/tb_wb_burst_reader.sv
`timescale 1ns/1ps
module tb_wb_burst_reader;
   localparam int BL = 8;
   localparam int FD = 16;
`ifdef WB_READER_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wshb_if wb_bus (.clk(clk), .rst(rst));

   logic        start;
   logic [31:0] base_adr;
   logic [15:0] word_count;
   logic        busy, done, err_flag, rd_en, rd_valid;
   logic [31:0] rd_data;

   wb_burst_reader #(.BURST_LEN(BL), .FIFO_DEPTH(FD)) dut (
      .wb_m       (wb_bus.master),
      .start      (start),
      .base_adr   (base_adr),
      .word_count (word_count),
      .busy       (busy),
      .done       (done),
      .err_flag   (err_flag),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Slave / consumer controls set by the main sequence
   int          wait_min = 0, wait_max = 0, rty_pct = 0;
   int          rd_mode = 0, pop_budget = 0;
   bit          err_armed = 1'b0;
   logic [31:0] err_adr = 32'h0;

   // Reference model of the transfer
   bit          m_active = 0, m_in_burst = 0, m_waiting = 0, m_done_now = 0, m_err = 0;
   int          m_count = 0, m_acked = 0, m_bstart = 0, m_blen = 0;
   logic [31:0] m_base = 0;
   logic [31:0] q[$];

   // Observed statistics
   int          st_bursts = 0, st_dones = 0, st_pushes = 0, st_pops = 0, st_maxq = 0, st_cti7 = 0;
   logic [31:0] st_last_adr = 0;

   // Values presented before the edge being modelled
   bit          p_rst = 0, p_start = 0, p_ack = 0, p_err = 0, p_rd_en = 0, p_cyc = 0;
   bit          p_waiting = 0, p_active = 0;
   int          p_qsize = 0;
   logic [31:0] p_base = 0;
   logic [15:0] p_count = 0;
   int          wcnt = 0;

   function automatic int min_int(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // Monitor: model update for the edge just past, compare, then drive the
   // slave response and consumer pop for the next edge.
   initial begin
      bit          was_done, just_reset;
      int          pos;
      logic [2:0]  exp_cti;
      wb_bus.ack = 0; wb_bus.err = 0; wb_bus.rty = 0; wb_bus.dat_sm = 0; rd_en = 0;
      forever begin
         @(negedge clk);
         just_reset = 0;
         if (p_rst) begin
            m_active = 0; m_in_burst = 0; m_waiting = 0; m_done_now = 0; m_err = 0;
            q.delete();
            just_reset = 1;
         end else begin
            was_done = m_done_now;
            m_done_now = 0;
            if (was_done) m_active = 0;
            if (p_rd_en && q.size() > 0) begin
               void'(q.pop_front());
               st_pops++;
               if (rd_mode == 3) pop_budget--;
            end
            if (m_in_burst) begin
               if (p_err) begin
                  m_in_burst = 0; m_err = 1; m_done_now = 1;
               end else if (p_ack) begin
                  q.push_back(mem_val(m_base + 32'(m_acked) * 32'd4));
                  m_acked++;
                  st_pushes++;
                  if (m_acked - m_bstart == m_blen) begin
                     m_in_burst = 0;
                     if (m_acked == m_count) m_done_now = 1;
                     else m_waiting = 1;
                  end
               end
            end else if (p_waiting && (FD - p_qsize) >= min_int(BL, m_count - m_acked)) begin
               m_waiting = 0;
               m_in_burst = 1;
               m_bstart = m_acked;
               m_blen = min_int(BL, m_count - m_acked);
            end
            if (!p_active && p_start) begin
               m_active = 1;
               m_base = {p_base[31:2], 2'b00};
               m_count = int'(p_count);
               m_acked = 0;
               m_err = 0;
               if (p_count == 0) m_done_now = 1;
               else m_waiting = 1;
            end
         end

         // Compare against the model
         check("busy", busy, m_active);
         check("done", done, m_done_now);
         check("cyc", wb_bus.cyc, m_in_burst);
         check("stb", wb_bus.stb, m_in_burst);
         check("we", wb_bus.we, 0);
         check("sel", wb_bus.sel, 4'hF);
         check("dat_ms", wb_bus.dat_ms, 0);
         check("bte", wb_bus.bte, 0);
         check("err_flag", err_flag, m_err);
         check("rd_valid", rd_valid, q.size() > 0);
         if (q.size() > 0) check("rd_data", rd_data, q[0]);
         if (m_in_burst) begin
            pos = m_acked - m_bstart;
            exp_cti = (m_blen == 1) ? 3'b000 : ((pos == m_blen - 1) ? 3'b111 : 3'b010);
            check("adr", wb_bus.adr, m_base + 32'(m_acked) * 32'd4);
            check("cti", wb_bus.cti, exp_cti);
         end
         if (just_reset) begin
            check("reset_adr", wb_bus.adr, 0);
            check("reset_cti", wb_bus.cti, 0);
         end

         // Statistics from the DUT
         if (wb_bus.cyc && !p_cyc) st_bursts++;
         if (wb_bus.cyc) st_last_adr = wb_bus.adr;
         if (wb_bus.cyc && wb_bus.cti == 3'b111) st_cti7++;
         if (done) st_dones++;
         if (q.size() > st_maxq) st_maxq = q.size();

         // Slave response for the coming edge
         wb_bus.ack = 0; wb_bus.err = 0; wb_bus.rty = 0; wb_bus.dat_sm = $urandom;
         if (!rst && wb_bus.cyc && wb_bus.stb) begin
            if (wcnt > 0) wcnt--;
            else if (err_armed && wb_bus.adr == err_adr) begin
               wb_bus.err = 1; err_armed = 0;
            end else if ($urandom_range(99) < rty_pct) begin
               wb_bus.rty = 1;
            end else begin
               wb_bus.ack = 1;
               wb_bus.dat_sm = mem_val(wb_bus.adr);
               wcnt = $urandom_range(wait_max, wait_min);
            end
         end else begin
            wcnt = $urandom_range(wait_max, wait_min);
         end
         case (rd_mode)
            1:       rd_en = 1;
            2:       rd_en = $urandom_range(1);
            3:       rd_en = (pop_budget > 0);
            default: rd_en = 0;
         endcase

         // Capture what the DUT will see at the coming edge
         p_rst = rst; p_start = start; p_base = base_adr; p_count = word_count;
         p_ack = wb_bus.ack; p_err = wb_bus.err & ERR_EN; p_rd_en = rd_en;
         p_qsize = q.size(); p_waiting = m_waiting; p_active = m_active; p_cyc = wb_bus.cyc;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic drain(input int n);
      rd_mode = 1;
      repeat (n) step();
      rd_mode = 0;
      step();
   endtask

   task automatic wait_done(input int budget, input bit junk_starts);
      bit seen = 0;
      for (int i = 0; i < budget; i++) begin
         if (done) begin
            seen = 1;
            break;
         end
         start = junk_starts && ($urandom_range(7) == 0);
         base_adr = $urandom;
         word_count = 16'($urandom_range(40));
         step();
      end
      start = 0;
      check("xfer_timeout", 32'(seen), 1);
      step();
   endtask

   task automatic do_xfer(input logic [31:0] b, input logic [15:0] n, input bit junk);
      base_adr = b; word_count = n; start = 1;
      step();
      start = 0;
      wait_done(3000, junk);
   endtask

   initial begin
      int b_bursts, b_push, b_pops, b_dones, b_cti7;
      int exp_push6, exp_err6;
      rst = 1; start = 0; base_adr = 0; word_count = 0;
      repeat (3) step();
      rst = 0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cyc", wb_bus.cyc, 0);
      check("rst_rd_valid", rd_valid, 0);
      step();

      // 1) single 8-beat burst at 0x100
      b_bursts = st_bursts; b_push = st_pushes; b_cti7 = st_cti7; b_pops = st_pops;
      do_xfer(32'h100, 16'd8, 0);
      check("t1_bursts", st_bursts - b_bursts, 1);
      check("t1_words", st_pushes - b_push, 8);
      check("t1_last_adr", st_last_adr, 32'h11C);
      check("t1_cti_end_beats", st_cti7 - b_cti7, 1);
      drain(12);
      check("t1_pops", st_pops - b_pops, 8);
      check("t1_empty", rd_valid, 0);

      // 2) 20 words with no consumer: stalls after two bursts
      b_bursts = st_bursts; b_push = st_pushes; b_pops = st_pops;
      base_adr = 32'h1000; word_count = 16'd20; start = 1;
      step();
      start = 0;
      repeat (60) step();
      check("t2_stall_bursts", st_bursts - b_bursts, 2);
      check("t2_stall_words", st_pushes - b_push, 16);
      check("t2_stall_busy", busy, 1);
      rd_mode = 3; pop_budget = 4;
      wait_done(300, 0);
      rd_mode = 0;
      check("t2_bursts", st_bursts - b_bursts, 3);
      check("t2_words", st_pushes - b_push, 20);
      drain(25);
      check("t2_pops", st_pops - b_pops, 20);

      // 3) one-word classic cycle, then zero words
      b_bursts = st_bursts; b_push = st_pushes; b_dones = st_dones;
      do_xfer(32'h43, 16'd1, 0);
      check("t3_one_bursts", st_bursts - b_bursts, 1);
      check("t3_one_words", st_pushes - b_push, 1);
      check("t3_one_done", st_dones - b_dones, 1);
      drain(3);
      b_bursts = st_bursts; b_push = st_pushes; b_dones = st_dones;
      do_xfer(32'h80, 16'd0, 0);
      check("t3_zero_bursts", st_bursts - b_bursts, 0);
      check("t3_zero_words", st_pushes - b_push, 0);
      check("t3_zero_done", st_dones - b_dones, 1);

      // 4) three wait states per beat, consumer always ready
      wait_min = 3; wait_max = 3; rd_mode = 1; st_maxq = 0;
      b_push = st_pushes;
      do_xfer(32'h300, 16'd12, 0);
      step();
      rd_mode = 0;
      check("t4_words", st_pushes - b_push, 12);
      check("t4_fifo_le1", 32'(st_maxq <= 1), 1);

      // 5) reset during beat 3, then a normal transfer
      b_push = st_pushes;
      base_adr = 32'h400; word_count = 16'd16; start = 1;
      step();
      start = 0;
      for (int i = 0; i < 100 && st_pushes - b_push < 2; i++) step();
      check("t5_reach_beat3", st_pushes - b_push, 2);
      b_dones = st_dones;
      rst = 1;
      step();
      rst = 0;
      check("t5_cyc", wb_bus.cyc, 0);
      check("t5_busy", busy, 0);
      check("t5_rd_valid", rd_valid, 0);
      repeat (5) step();
      check("t5_no_done", st_dones - b_dones, 0);
      wait_min = 0; wait_max = 0;
      b_push = st_pushes; b_dones = st_dones;
      do_xfer(32'h500, 16'd5, 0);
      check("t5_restart_words", st_pushes - b_push, 5);
      check("t5_restart_done", st_dones - b_dones, 1);
      drain(8);

      // 6) err on beat 2 of a burst at 0x200
`ifdef WB_READER_ERR_EN
      exp_push6 = 1; exp_err6 = 1;
`else
      exp_push6 = 8; exp_err6 = 0;
`endif
      b_push = st_pushes;
      err_armed = 1; err_adr = 32'h204;
      do_xfer(32'h200, 16'd8, 0);
      check("t6_words", st_pushes - b_push, exp_push6);
      check("t6_err_flag", err_flag, exp_err6);
      err_armed = 0;
      drain(10);

      // Random transfers: wait states, retries, random consumer, junk starts
      rty_pct = 10; rd_mode = 2;
      for (int t = 0; t < 30; t++) begin
         logic [31:0] b;
         wait_min = 0; wait_max = $urandom_range(3);
         b = ($urandom_range(4) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(31))) : $urandom;
         do_xfer(b, 16'($urandom_range(40)), 1);
         rd_mode = 2;
      end
      rty_pct = 0;
      drain(40);
      check("final_empty", rd_valid, 0);
      check("final_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
